cdc_word_arbiter: RTL and testbench
===================================

// Module: cdc_word_arbiter
// PURPOSE
//  Round-robin arbiter/scheduler for the single-word fast_to_slow crossing, in the fast clock domain.
//  Shares the one S-bit crossing among N requesters.
//  Holds each granted word stable on the crossing input for HOLD cycles, then forces GAP idle cycles.
//  The slow side therefore always samples a settled word. Output xfer_data drives fast_to_slow.async_data.
// PARAMETERS
//  S     12  word width (matches fast_to_slow S)
//  N     4   number of requesters, N >= 2
//  HOLD  4   cycles xfer_data held with xfer_valid=1, HOLD >= 1
//  GAP   2   idle cycles after HOLD before next grant, GAP >= 1
// PORTS
//  clk       in   1                 fast clock; all logic on rising edge
//  reset     in   1                 synchronous, active-high
//  req       in   N                 request per requester; level, held until grant
//  req_data  in   N*S               packed words; requester i at [i*S +: S]
//  grant     out  N                 one-hot, 1-cycle pulse: requester's word captured
//  xfer_data out  S                 word to crossing (async_data)
//  xfer_valid out 1                 high while xfer_data is in its HOLD window
//  xfer_src  out  $clog2(N)         index of requester owning xfer_data
//  busy      out  1                 high in HOLD or GAP state
// BEHAVIOUR
//  - Reset: grant=0, xfer_data=0, xfer_valid=0, xfer_src=0, busy=0, state=IDLE, last_src=N-1.
//    Reset mid-operation aborts the HOLD/GAP window at once; the in-flight word is dropped and never re-granted.
//  - All outputs are registered.
//  - FSM IDLE -> HOLD -> GAP -> IDLE. Counter cnt is sized for max(HOLD,GAP).
//  - IDLE, |req at edge T:
//    - Winner = first set req[(last_src+1+k)%N], k=0..N-1.
//    - At T+1: xfer_data=req_data[winner], xfer_src=winner, grant[winner]=1 (only this cycle).
//    - Also at T+1: xfer_valid=1, last_src=winner, state=HOLD.
//  - IDLE with req=0: stay; xfer_data keeps its last value; xfer_valid=0.
//  - HOLD: xfer_valid=1 for exactly HOLD cycles (T+1..T+HOLD). xfer_data/xfer_src frozen; req ignored.
//  - GAP: xfer_valid=0 for GAP cycles (T+HOLD+1..T+HOLD+GAP). xfer_data still frozen. Then IDLE.
//  - IDLE samples req on the cycle after GAP ends. With continuous requests, grants are spaced HOLD+GAP+1 cycles apart.
//  - Requester must hold req and req_data stable until it sees grant.
//    The requester then drops req next cycle. If req is still high after grant, it is treated as a new request.
//  - Dropping req before it is sampled in IDLE: no grant, no effect.
//  - Round-robin wrap: after src N-1, src 0 has top priority. Fair: no requester waits more than N grants.
//  - No arithmetic beyond the counter and modulo-N pointer. Pointer wraps N-1 -> 0. No overflow cases.
// TESTING (S=12,N=4,HOLD=4,GAP=2)
//  1 Hold reset 3 cycles with random req -> all outputs 0, busy 0; first grant after reset goes to the lowest set req.
//  2 req=0010, req_data[1]=12'hABC at T (dropped on grant) -> grant=0010 at T+1.
//    Also: xfer_data=ABC, xfer_src=1, xfer_valid=1 at T+1..T+4, 0 at T+5..T+6; xfer_data=ABC through T+6.
//  3 req=1111 held (each dropped one cycle after its grant, re-raised next) -> grant order 0,1,2,3,0; grants 7 cycles apart.
//  4 req=0101 continuous -> grants alternate src 0,2,0,2; src 1/3 never granted.
//  5 Grant src 3, then req=1001 -> src 0 granted next (wrap); then src 3.
//  6 Reset at HOLD cycle 2 -> next cycle xfer_valid=0, busy=0. Then req=1010 -> grant=0010.

Source files
------------

// File: rtl/cdc_word_arbiter.sv
// ---------------------------------------------------------------------------
// cdc_word_arbiter
// Round-robin scheduler for the single-word fast-to-slow crossing. Runs in
// the fast clock domain and shares one S-bit crossing among N requesters.
// A granted word is held on o_xfer_data with o_xfer_valid=1 for HOLD cycles,
// then GAP idle cycles follow before the next grant. This way the slow side
// only ever samples a settled word.
//
// Ports
//   i_clk        fast clock; all logic on the rising edge
//   i_reset      synchronous, active-high reset
//   i_req        per-requester level request, held until grant
//   i_req_data   packed request words, requester i at [i*S +: S]
//   o_grant      one-hot, single-cycle pulse: requester's word captured
//   o_xfer_data  word driven to the crossing (async_data)
//   o_xfer_valid high while o_xfer_data is inside its HOLD window
//   o_xfer_src   index of the requester that owns o_xfer_data
//   o_busy       high while in HOLD or GAP
// ---------------------------------------------------------------------------
module cdc_word_arbiter #(
    parameter int unsigned  S     = 12,
    parameter int unsigned  N     = 4,
    parameter int unsigned  HOLD  = 4,
    parameter int unsigned  GAP   = 2,
    localparam int unsigned SRC_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [N-1:0]      i_req,
    input  logic [N*S-1:0]    i_req_data,
    output logic [N-1:0]      o_grant,
    output logic [S-1:0]      o_xfer_data,
    output logic              o_xfer_valid,
    output logic [SRC_W-1:0]  o_xfer_src,
    output logic              o_busy
);

    localparam int unsigned CNT_MAX = (HOLD > GAP) ? HOLD : GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [SRC_W-1:0] r_last_src;
    logic [SRC_W-1:0] w_last_src_nxt;

    logic [N-1:0]     r_grant;
    logic [N-1:0]     w_grant_nxt;
    logic [S-1:0]     r_xfer_data;
    logic [S-1:0]     w_xfer_data_nxt;
    logic             r_xfer_valid;
    logic             w_xfer_valid_nxt;
    logic [SRC_W-1:0] r_xfer_src;
    logic [SRC_W-1:0] w_xfer_src_nxt;
    logic             r_busy;
    logic             w_busy_nxt;

    logic             w_win_found;
    logic [SRC_W-1:0] w_winner;
    logic [S-1:0]     w_win_data;
    int unsigned      w_idx;

    // Round-robin search: start one past the last owner, wrap N-1 -> 0.
    always_comb begin
        w_win_found = 1'b0;
        w_winner    = '0;
        w_idx       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = 32'(r_last_src) + 32'd1 + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!w_win_found && i_req[SRC_W'(w_idx)]) begin
                w_win_found = 1'b1;
                w_winner    = SRC_W'(w_idx);
            end
        end
    end

    // Word of the selected requester.
    always_comb begin
        w_win_data = i_req_data[32'(w_winner) * S +: S];
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_last_src_nxt   = r_last_src;
        w_grant_nxt      = '0;
        w_xfer_data_nxt  = r_xfer_data;
        w_xfer_src_nxt   = r_xfer_src;
        w_xfer_valid_nxt = 1'b0;
        w_busy_nxt       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_win_found) begin
                    w_state_nxt           = ST_HOLD;
                    w_cnt_nxt             = CNT_W'(HOLD - 1);
                    w_last_src_nxt        = w_winner;
                    w_grant_nxt[w_winner] = 1'b1;
                    w_xfer_data_nxt       = w_win_data;
                    w_xfer_src_nxt        = w_winner;
                    w_xfer_valid_nxt      = 1'b1;
                    w_busy_nxt            = 1'b1;
                end
            end

            // Counter holds the number of HOLD cycles still to follow.
            ST_HOLD: begin
                w_busy_nxt = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = CNT_W'(GAP - 1);
                end else begin
                    w_cnt_nxt        = r_cnt - CNT_W'(1);
                    w_xfer_valid_nxt = 1'b1;
                end
            end

            // Last GAP cycle drops busy so IDLE samples req right after.
            ST_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt  = r_cnt - CNT_W'(1);
                    w_busy_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any in-flight word.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_last_src   <= SRC_W'(N - 1);
            r_grant      <= '0;
            r_xfer_data  <= '0;
            r_xfer_valid <= 1'b0;
            r_xfer_src   <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_last_src   <= w_last_src_nxt;
            r_grant      <= w_grant_nxt;
            r_xfer_data  <= w_xfer_data_nxt;
            r_xfer_valid <= w_xfer_valid_nxt;
            r_xfer_src   <= w_xfer_src_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    assign o_grant      = r_grant;
    assign o_xfer_data  = r_xfer_data;
    assign o_xfer_valid = r_xfer_valid;
    assign o_xfer_src   = r_xfer_src;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_cdc_word_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdc_word_arbiter
// Self-checking bench for cdc_word_arbiter (S=12, N=4, HOLD=4, GAP=2).
// A time-based reference model (grant cycle + window lengths) predicts every
// output each cycle; a vector table and short grant-order sequences cover the
// timing, wrap and mid-operation reset corner cases.
// ---------------------------------------------------------------------------
module tb_cdc_word_arbiter;

    localparam int S    = 12;
    localparam int N    = 4;
    localparam int HOLD = 4;
    localparam int GAP  = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*S-1:0] req_data;
    logic [N-1:0]   grant;
    logic [S-1:0]   xfer_data;
    logic           xfer_valid;
    logic [1:0]     xfer_src;
    logic           busy;

    always #5 clk = ~clk;

    cdc_word_arbiter #(.S(S), .N(N), .HOLD(HOLD), .GAP(GAP)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_req        (req),
        .i_req_data   (req_data),
        .o_grant      (grant),
        .o_xfer_data  (xfer_data),
        .o_xfer_valid (xfer_valid),
        .o_xfer_src   (xfer_src),
        .o_busy       (busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: remembers only when the last grant happened and to whom.
    int           m_cyc    = 0;
    int           m_gnt_at = -1000;
    int           m_last   = N - 1;
    int           m_src    = 0;
    logic [S-1:0] m_data   = '0;
    bit           chk_model = 1'b1;

    task automatic model_edge();
        int c0;
        c0 = m_cyc;
        m_cyc++;
        if (reset) begin
            m_gnt_at = -1000;
            m_last   = N - 1;
            m_src    = 0;
            m_data   = '0;
        end else if (!(c0 >= m_gnt_at && c0 < m_gnt_at + HOLD + GAP) && req != '0) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_last + 1 + k) % N;
                if (req[idx]) begin
                    m_src = idx;
                    break;
                end
            end
            m_last   = m_src;
            m_data   = req_data[m_src*S +: S];
            m_gnt_at = m_cyc;
        end
    endtask

    task automatic check_model();
        logic [N-1:0] e_gnt;
        logic         e_val;
        logic         e_busy;
        e_gnt = '0;
        if (m_cyc == m_gnt_at) e_gnt[m_src] = 1'b1;
        e_val  = (m_cyc >= m_gnt_at) && (m_cyc < m_gnt_at + HOLD);
        e_busy = (m_cyc >= m_gnt_at) && (m_cyc < m_gnt_at + HOLD + GAP);
        chk("mdl_grant", 64'(grant),      64'(e_gnt));
        chk("mdl_valid", 64'(xfer_valid), 64'(e_val));
        chk("mdl_busy",  64'(busy),       64'(e_busy));
        chk("mdl_data",  64'(xfer_data),  64'(m_data));
        chk("mdl_src",   64'(xfer_src),   64'(m_src));
    endtask

    // One clock: model sees the same inputs as the DUT edge, outputs checked 1ns later.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        if (chk_model) check_model();
    endtask

    typedef struct {
        logic           rst;
        logic [N-1:0]   req;
        logic [N*S-1:0] data;
        logic [N-1:0]   e_gnt;
        logic           e_val;
        logic           e_busy;
        logic [1:0]     e_src;
        logic [S-1:0]   e_data;
    } vec_t;

    vec_t tbl[12];

    int g_src[$];
    int g_cyc[$];

    // Requesters drive 'pattern'; with drop set, a granted requester lowers
    // req for one cycle then raises it again.
    task automatic run_grants(input logic [N-1:0] pattern, input bit drop, input int ncyc);
        g_src.delete();
        g_cyc.delete();
        req = pattern;
        for (int c = 0; c < ncyc; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (grant[i]) begin
                    g_src.push_back(i);
                    g_cyc.push_back(m_cyc);
                end
            end
            req = drop ? (pattern & ~grant) : pattern;
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        req   = '0;
        repeat (n) step();
        reset = 1'b0;
    endtask

    task automatic chk_order(input string name, input int exp_src[], input int spacing);
        chk({name, "_count"}, 64'(g_src.size()), 64'(exp_src.size()));
        for (int i = 0; i < exp_src.size() && i < g_src.size(); i++) begin
            chk({name, "_src"}, 64'(g_src[i]), 64'(exp_src[i]));
            if (i > 0 && spacing > 0)
                chk({name, "_gap"}, 64'(g_cyc[i] - g_cyc[i-1]), 64'(spacing));
        end
    endtask

    initial begin
        logic [N*S-1:0] d;
        d = {12'h333, 12'h222, 12'hABC, 12'h111};

        //          rst  req      data e_gnt    val   busy  src   data
        tbl[0]  = '{1'b0, 4'b0110, d, 4'b0010, 1'b1, 1'b1, 2'd1, 12'hABC};
        tbl[1]  = '{1'b0, 4'b0100, d, 4'b0000, 1'b1, 1'b1, 2'd1, 12'hABC};
        tbl[2]  = '{1'b0, 4'b0100, d, 4'b0000, 1'b1, 1'b1, 2'd1, 12'hABC};
        tbl[3]  = '{1'b0, 4'b0100, d, 4'b0000, 1'b1, 1'b1, 2'd1, 12'hABC};
        tbl[4]  = '{1'b0, 4'b0100, d, 4'b0000, 1'b0, 1'b1, 2'd1, 12'hABC};
        tbl[5]  = '{1'b0, 4'b0100, d, 4'b0000, 1'b0, 1'b1, 2'd1, 12'hABC};
        tbl[6]  = '{1'b0, 4'b0100, d, 4'b0000, 1'b0, 1'b0, 2'd1, 12'hABC};
        tbl[7]  = '{1'b0, 4'b0100, d, 4'b0100, 1'b1, 1'b1, 2'd2, 12'h222};
        tbl[8]  = '{1'b0, 4'b0000, d, 4'b0000, 1'b1, 1'b1, 2'd2, 12'h222};
        tbl[9]  = '{1'b1, 4'b0000, d, 4'b0000, 1'b0, 1'b0, 2'd0, 12'h000};
        tbl[10] = '{1'b0, 4'b1010, d, 4'b0010, 1'b1, 1'b1, 2'd1, 12'hABC};
        tbl[11] = '{1'b0, 4'b1000, d, 4'b0000, 1'b1, 1'b1, 2'd1, 12'hABC};

        // Reset held with random requests: everything stays at zero.
        reset    = 1'b1;
        req_data = d;
        for (int i = 0; i < 3; i++) begin
            req = 4'($urandom);
            step();
            chk("rst_grant", 64'(grant),      64'd0);
            chk("rst_data",  64'(xfer_data),  64'd0);
            chk("rst_valid", 64'(xfer_valid), 64'd0);
            chk("rst_src",   64'(xfer_src),   64'd0);
            chk("rst_busy",  64'(busy),       64'd0);
        end

        // Grant timing, window lengths, mid-HOLD reset.
        for (int i = 0; i < 12; i++) begin
            reset    = tbl[i].rst;
            req      = tbl[i].req;
            req_data = tbl[i].data;
            step();
            chk("tbl_grant", 64'(grant),      64'(tbl[i].e_gnt));
            chk("tbl_valid", 64'(xfer_valid), 64'(tbl[i].e_val));
            chk("tbl_busy",  64'(busy),       64'(tbl[i].e_busy));
            chk("tbl_src",   64'(xfer_src),   64'(tbl[i].e_src));
            chk("tbl_data",  64'(xfer_data),  64'(tbl[i].e_data));
        end

        // All four requesting: strict rotation, grants HOLD+GAP+1 apart.
        do_reset(2);
        run_grants(4'b1111, 1'b1, 32);
        chk_order("rr_all", '{0, 1, 2, 3, 0}, HOLD + GAP + 1);

        // Two continuous requesters alternate; the idle ones never win.
        do_reset(2);
        run_grants(4'b0101, 1'b0, 24);
        chk_order("rr_0101", '{0, 2, 0, 2}, HOLD + GAP + 1);

        // Pointer wrap: after src 3, src 0 has top priority.
        do_reset(2);
        run_grants(4'b1000, 1'b1, 3);
        chk_order("wrap_a", '{3}, 0);
        run_grants(4'b1001, 1'b0, 16);
        chk_order("wrap_b", '{0, 3}, HOLD + GAP + 1);

        // Random traffic with occasional resets against the model.
        for (int i = 0; i < 1500; i++) begin
            reset    = (($urandom % 64) == 0);
            req      = (($urandom % 4) == 0) ? 4'b0000 : 4'($urandom);
            req_data = {16'($urandom), $urandom};
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
